fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_skid_fifo.sv | 57 +++++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Fetch control: running, stopped at PC 0, or stopped on a bad redirect.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry buffer between the instruction memory response and decode.
module fetch_skid_fifo
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output fetch_pkt_t head
);

  fetch_pkt_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;
  logic       pop_ok;
  logic       push_ok;

  // Guard against popping empty / pushing full without a matching pop.
  always_comb begin
    pop_ok  = pop && (cnt != 2'd0);
    push_ok = push && ((cnt != 2'd2) || pop_ok);
  end

  // Storage and pointers; flush drops contents but leaves stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_pkt;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, single outstanding memory read, decode buffer.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] pc_init = 32'h80020000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic        fault
);

  fetch_state_e    state;
  fetch_state_e    state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;

  logic            pop;
  logic            push;
  logic            issue;
  logic            redirect_acc;
  logic            misaligned;
  logic [2:0]      occ_after_pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_pkt_t      fifo_head;
  fetch_pkt_t      push_pkt;

  // Next state and per-cycle control; a redirect overrides push and issue.
  always_comb begin
    state_n       = state;
    issue         = 1'b0;
    pop           = !fifo_empty && dec_ready;
    redirect_acc  = redirect_valid && (state == ST_RUN);
    misaligned    = |(redirect_target[1:0] & WORD_ALIGN_MASK);
    push          = inflight && !redirect_acc;
    occ_after_pop = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1)) - 3'(pop);
    case (state)
      ST_RUN: begin
        if (redirect_acc) begin
          if (misaligned) begin
            state_n = ST_FAULT;
          end else if (redirect_target == '0) begin
            state_n = ST_HALTED;
          end
        end else if (pc == '0) begin
          state_n = ST_HALTED;
        end else if ((occ_after_pop + 3'(inflight)) <= 3'd1) begin
          issue = 1'b1;
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_n;
    end
  end

  // PC and outstanding-request tracking; the response in a redirect cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= pc_init;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
      end
      if (redirect_acc && !misaligned) begin
        pc <= redirect_target;
      end else if (issue) begin
        pc <= pc + XLEN'(PC_STEP);
      end
    end
  end

  assign push_pkt = '{pc: req_pc, instr: instr_in};

  fetch_skid_fifo u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_pkt (push_pkt),
    .pop      (pop),
    .flush    (redirect_acc),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign instr_addr = pc;
  assign dec_valid  = !fifo_empty;
  assign dec_instr  = fifo_head.instr;
  assign dec_pc     = fifo_head.pc;
  assign halted     = (state == ST_HALTED);
  assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns ~address one cycle later.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_addr;
  logic [31:0] instr_in = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.pc_init(32'h80020000)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_addr      (instr_addr),
    .instr_in        (instr_in),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory model.
  always @(posedge clk) instr_in <= ~instr_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Assert reset for one edge, check the asynchronous values, release; returns in the first run cycle.
  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_instr_addr", instr_addr, 32'h80020000);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    step();
    step();
    do_reset();

    // Streaming with decode always ready.
    check("s_c0_addr", instr_addr, 32'h80020000);
    check("s_c0_valid", 32'(dec_valid), 32'd0);
    step();
    check("s_c1_addr", instr_addr, 32'h80020004);
    check("s_c1_valid", 32'(dec_valid), 32'd0);
    step();
    check("s_c2_valid", 32'(dec_valid), 32'd1);
    check("s_c2_pc", dec_pc, 32'h80020000);
    check("s_c2_instr", dec_instr, ~32'h80020000);
    step();
    check("s_c3_pc", dec_pc, 32'h80020004);
    step();
    check("s_c4_pc", dec_pc, 32'h80020008);
    check("s_c4_instr", dec_instr, ~32'h80020008);

    // Mid-stream reset, then back-pressure from decode.
    do_reset();
    step();
    step();
    check("bp_first_valid", 32'(dec_valid), 32'd1);
    check("bp_first_pc", dec_pc, 32'h80020000);
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", 32'(dec_valid), 32'd1);
      check("bp_hold_pc", dec_pc, 32'h80020000);
      check("bp_hold_addr", instr_addr, 32'h80020008);
    end
    step();
    dec_ready = 1'b1;
    check("bp_rel_pc0", dec_pc, 32'h80020000);
    step();
    check("bp_rel_pc1", dec_pc, 32'h80020004);
    step();
    check("bp_rel_pc2", dec_pc, 32'h80020008);
    check("bp_rel_instr2", dec_instr, ~32'h80020008);
    step();
    check("bp_rel_pc3", dec_pc, 32'h8002000C);
    step();
    check("bp_rel_pc4", dec_pc, 32'h80020010);

    // Redirect while a response is in flight.
    redirect_valid = 1'b1;
    redirect_target = 32'h80020184;
    step();
    redirect_valid = 1'b0;
    check("rd_addr", instr_addr, 32'h80020184);
    check("rd_valid0", 32'(dec_valid), 32'd0);
    step();
    check("rd_valid1", 32'(dec_valid), 32'd0);
    check("rd_addr1", instr_addr, 32'h80020188);
    step();
    check("rd_valid2", 32'(dec_valid), 32'd1);
    check("rd_pc", dec_pc, 32'h80020184);
    check("rd_instr", dec_instr, ~32'h80020184);
    step();
    check("rd_pc_next", dec_pc, 32'h80020188);

    // Redirect to zero halts; later redirects are ignored.
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("h_halted", 32'(halted), 32'd1);
    check("h_addr", instr_addr, 32'h0);
    check("h_valid", 32'(dec_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h80020000;
    step();
    redirect_valid = 1'b0;
    check("h_ign_addr", instr_addr, 32'h0);
    step();
    check("h_ign_valid", 32'(dec_valid), 32'd0);
    check("h_still_halted", 32'(halted), 32'd1);
    check("h_no_fault", 32'(fault), 32'd0);

    // PC wrap from FFFFFFFC halts; buffered words still drain.
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFFFFF8;
    step();
    redirect_valid = 1'b0;
    check("w_c1_addr", instr_addr, 32'hFFFFFFF8);
    step();
    check("w_c2_addr", instr_addr, 32'hFFFFFFFC);
    step();
    check("w_c3_pc", dec_pc, 32'hFFFFFFF8);
    check("w_c3_halted", 32'(halted), 32'd0);
    check("w_c3_addr", instr_addr, 32'h0);
    step();
    check("w_c4_halted", 32'(halted), 32'd1);
    check("w_c4_valid", 32'(dec_valid), 32'd1);
    check("w_c4_pc", dec_pc, 32'hFFFFFFFC);
    step();
    check("w_c5_valid", 32'(dec_valid), 32'd0);
    check("w_c5_addr", instr_addr, 32'h0);

    // Misaligned redirect faults; later redirect ignored.
    do_reset();
    step();
    step();
    step();
    check("f_pre_pc", dec_pc, 32'h80020004);
    redirect_valid = 1'b1;
    redirect_target = 32'h80020006;
    step();
    redirect_valid = 1'b0;
    check("f_fault", 32'(fault), 32'd1);
    check("f_valid", 32'(dec_valid), 32'd0);
    check("f_addr", instr_addr, 32'h8002000C);
    check("f_halted", 32'(halted), 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h80020000;
    step();
    redirect_valid = 1'b0;
    check("f_ign_addr", instr_addr, 32'h8002000C);
    check("f_ign_fault", 32'(fault), 32'd1);
    step();
    check("f_ign_valid", 32'(dec_valid), 32'd0);
    check("f_ign_addr2", instr_addr, 32'h8002000C);

    // Reset clears the fault.
    do_reset();
    step();
    step();
    check("end_valid", 32'(dec_valid), 32'd1);
    check("end_pc", dec_pc, 32'h80020000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
